// File: rtl/lcd_defs_pkg.sv
// rtl/lcd_defs_pkg.sv - shared constants, state encoding and pixel types for the LCD writer
package lcd_defs;

  localparam int RED_W   = 5;
  localparam int GREEN_W = 6;
  localparam int BLUE_W  = 5;
  localparam int PIX_W   = 1 + RED_W + GREEN_W + BLUE_W;

  localparam logic [7:0] LCD_CMD_RAMWR = 8'h2C;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_LO   = 2'd3;

  typedef struct packed {
    logic [RED_W-1:0]   red;
    logic [GREEN_W-1:0] green;
    logic [BLUE_W-1:0]  blue;
  } rgb565_t;

  typedef struct packed {
    logic    sof;
    rgb565_t rgb;
  } pixel_t;

  function automatic logic [7:0] hi_byte(input rgb565_t p);
    return {p.red, p.green[5:3]};
  endfunction

  function automatic logic [7:0] lo_byte(input rgb565_t p);
    return {p.green[2:0], p.blue};
  endfunction

endpackage

// File: rtl/rgb565_lcd_writer_sync_fifo.sv
// rtl/rgb565_lcd_writer_sync_fifo.sv - single-clock FIFO with full/empty flags
// The head entry comes straight from the storage registers so a consumer can decode it on the pop cycle.
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rgb565_lcd_writer.sv
// rtl/rgb565_lcd_writer.sv - buffers RGB565 pixels and writes them to an 8080-style 8-bit LCD bus
// Frames start with the RAMWR command; every pixel is sent as a high byte then a low byte.
module rgb565_lcd_writer
  import lcd_defs::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [RED_W-1:0]     i_red,
  input  logic [GREEN_W-1:0]   i_green,
  input  logic [BLUE_W-1:0]    i_blue,
  input  logic                 i_sof,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [7:0]           o_lcd_data,
  output logic                 o_lcd_dc,
  output logic                 o_lcd_wr_n,
  output logic                 o_lcd_cs_n,
  output logic                 o_busy
);

  localparam int BYTE_CYCLES = WR_LOW_CYCLES + WR_HIGH_CYCLES;
  localparam int PH_W        = $clog2(BYTE_CYCLES);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(BYTE_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_RISE = PH_W'(WR_LOW_CYCLES);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

  pixel_t          in_pix;
  pixel_t          head;
  rgb565_t         pix;
  logic [1:0]      state;
  logic [PH_W-1:0] phase;
  logic [PH_W-1:0] phase_nxt;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic            byte_done;

  assign in_pix    = '{sof: i_sof, rgb: '{red: i_red, green: i_green, blue: i_blue}};
  assign o_ready   = !fifo_full;
  assign fifo_push = i_valid && !fifo_full;
  assign o_busy    = !fifo_empty || (state != ST_IDLE);

  sync_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (fifo_push),
    .wdata (in_pix),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A new pixel is taken either from idle or at the last clock of a LO byte, keeping cs_n low.
  always_comb begin
    byte_done = (phase == PH_LAST);
    phase_nxt = phase + PH_ONE;
    fifo_pop  = 1'b0;
    if (!fifo_empty) begin
      fifo_pop = (state == ST_IDLE) || ((state == ST_LO) && byte_done);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      phase      <= '0;
      pix        <= '0;
      o_lcd_data <= 8'h00;
      o_lcd_dc   <= 1'b1;
      o_lcd_wr_n <= 1'b1;
      o_lcd_cs_n <= 1'b1;
    end else if (fifo_pop) begin
      pix        <= head.rgb;
      phase      <= '0;
      o_lcd_wr_n <= 1'b0;
      o_lcd_cs_n <= 1'b0;
      if (head.sof) begin
        state      <= ST_CMD;
        o_lcd_data <= LCD_CMD_RAMWR;
        o_lcd_dc   <= 1'b0;
      end else begin
        state      <= ST_HI;
        o_lcd_data <= hi_byte(head.rgb);
        o_lcd_dc   <= 1'b1;
      end
    end else if (state != ST_IDLE) begin
      if (byte_done) begin
        phase <= '0;
        case (state)
          ST_CMD: begin
            state      <= ST_HI;
            o_lcd_data <= hi_byte(pix);
            o_lcd_dc   <= 1'b1;
            o_lcd_wr_n <= 1'b0;
          end
          ST_HI: begin
            state      <= ST_LO;
            o_lcd_data <= lo_byte(pix);
            o_lcd_dc   <= 1'b1;
            o_lcd_wr_n <= 1'b0;
          end
          default: begin
            state      <= ST_IDLE;
            o_lcd_cs_n <= 1'b1;
          end
        endcase
      end else begin
        phase <= phase_nxt;
        if (phase_nxt == PH_RISE) begin
          o_lcd_wr_n <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb565_lcd_writer.sv
// tb/tb_rgb565_lcd_writer.sv - directed checks of the LCD writer bus timing, byte stream and FIFO flow control
module tb_rgb565_lcd_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] red = '0;
  logic [5:0] green = '0;
  logic [4:0] blue = '0;
  logic       sof = 1'b0;
  logic       valid = 1'b0;
  logic       valid_bc = 1'b0;
  logic       ready, busy, ready_b, busy_b, ready_c, busy_c;
  logic [7:0] dat_v [3];
  logic       dc_v [3];
  logic       wr_v [3];
  logic       cs_v [3];

  always #5 clk = ~clk;

  rgb565_lcd_writer dut (
    .i_clk(clk), .i_rst(rst), .i_red(red), .i_green(green), .i_blue(blue),
    .i_sof(sof), .i_valid(valid), .o_ready(ready), .o_lcd_data(dat_v[0]),
    .o_lcd_dc(dc_v[0]), .o_lcd_wr_n(wr_v[0]), .o_lcd_cs_n(cs_v[0]), .o_busy(busy)
  );

  rgb565_lcd_writer #(.FIFO_DEPTH(4), .WR_LOW_CYCLES(1), .WR_HIGH_CYCLES(3)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_red(red), .i_green(green), .i_blue(blue),
    .i_sof(sof), .i_valid(valid_bc), .o_ready(ready_b), .o_lcd_data(dat_v[1]),
    .o_lcd_dc(dc_v[1]), .o_lcd_wr_n(wr_v[1]), .o_lcd_cs_n(cs_v[1]), .o_busy(busy_b)
  );

  rgb565_lcd_writer #(.FIFO_DEPTH(4), .WR_LOW_CYCLES(3), .WR_HIGH_CYCLES(1)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_red(red), .i_green(green), .i_blue(blue),
    .i_sof(sof), .i_valid(valid_bc), .o_ready(ready_c), .o_lcd_data(dat_v[2]),
    .o_lcd_dc(dc_v[2]), .o_lcd_wr_n(wr_v[2]), .o_lcd_cs_n(cs_v[2]), .o_busy(busy_c)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] cap_q [$];
  int         cs_lens [$];
  logic [8:0] exp_q [$];
  logic       stat_clr = 1'b0;

  logic       prev_wr [3];
  logic       prev_cs [3];
  int         lo_run [3], hi_run [3], cs_run [3];
  int         lo_min [3], lo_max [3], hi_min [3], hi_max [3];
  int         rise_cnt [3], cs_last [3];
  logic [8:0] cap_bc [2][8];

  // Bus monitor: captures {dc,data} at each wr_n rise and measures strobe and chip-select widths.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst || stat_clr) begin
        prev_wr[k] <= 1'b1;
        prev_cs[k] <= 1'b1;
        lo_run[k]  <= 0;
        hi_run[k]  <= 0;
        cs_run[k]  <= 0;
        if (stat_clr) begin
          lo_min[k] <= 999; lo_max[k] <= 0;
          hi_min[k] <= 999; hi_max[k] <= 0;
          rise_cnt[k] <= 0; cs_last[k] <= 0;
          if (k == 0) begin
            cap_q.delete();
            cs_lens.delete();
          end
        end
      end else begin
        prev_wr[k] <= wr_v[k];
        prev_cs[k] <= cs_v[k];
        lo_run[k]  <= wr_v[k] ? 0 : lo_run[k] + 1;
        hi_run[k]  <= (wr_v[k] && !cs_v[k]) ? hi_run[k] + 1 : 0;
        cs_run[k]  <= cs_v[k] ? 0 : cs_run[k] + 1;
        if (wr_v[k] && !prev_wr[k]) begin
          rise_cnt[k] <= rise_cnt[k] + 1;
          if (lo_run[k] < lo_min[k]) lo_min[k] <= lo_run[k];
          if (lo_run[k] > lo_max[k]) lo_max[k] <= lo_run[k];
          if (k == 0) cap_q.push_back({dc_v[k], dat_v[k]});
          else if (rise_cnt[k] < 8) cap_bc[k-1][rise_cnt[k]] <= {dc_v[k], dat_v[k]};
        end
        if ((!wr_v[k] && prev_wr[k] && !prev_cs[k] && !cs_v[k]) || (cs_v[k] && !prev_cs[k])) begin
          if (hi_run[k] < hi_min[k]) hi_min[k] <= hi_run[k];
          if (hi_run[k] > hi_max[k]) hi_max[k] <= hi_run[k];
        end
        if (cs_v[k] && !prev_cs[k]) begin
          cs_last[k] <= cs_run[k];
          if (k == 0) cs_lens.push_back(cs_run[k]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic s, input logic [4:0] r, input logic [5:0] g,
                      input logic [4:0] b, output bit stalled);
    int w;
    w = 0;
    stalled = 1'b0;
    @(negedge clk);
    sof = s; red = r; green = g; blue = b; valid = 1'b1;
    while (!ready && w < 400) begin
      stalled = 1'b1;
      @(negedge clk);
      w++;
    end
    if (!ready) chk("push_timeout", {31'd0, ready}, 32'd1);
    @(posedge clk);
    #1;
    if (s) exp_q.push_back({1'b0, 8'h2C});
    exp_q.push_back({1'b1, r, g[5:3]});
    exp_q.push_back({1'b1, g[2:0], b});
  endtask

  task automatic wait_idle(input int budget);
    int w;
    w = 0;
    @(negedge clk);
    while ((busy || !cs_v[0]) && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk("idle_reached", {31'd0, busy}, 32'd0);
    @(negedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), {23'd0, cap_q[i]}, {23'd0, exp_q[i]});
    end
  endtask

  task automatic clear_stats();
    @(posedge clk);
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    bit         st;
    int         stall_at;
    int         gap;
    int         w;
    logic [8:0] exp_bc [5];
    exp_bc = '{9'h02C, 9'h180, 9'h123, 9'h10C, 9'h11F};

    @(negedge clk);
    chk("rst_data", {24'd0, dat_v[0]}, 32'h00);
    chk("rst_dc", {31'd0, dc_v[0]}, 32'd1);
    chk("rst_wr_n", {31'd0, wr_v[0]}, 32'd1);
    chk("rst_cs_n", {31'd0, cs_v[0]}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);

    // Single pixel with first-byte latency
    clear_stats();
    push(1'b0, 5'h1F, 6'h2A, 5'h15, st);
    valid = 1'b0;
    @(negedge clk);
    chk("lat_cs_before", {31'd0, cs_v[0]}, 32'd1);
    @(negedge clk);
    chk("lat_cs", {31'd0, cs_v[0]}, 32'd0);
    chk("lat_wr", {31'd0, wr_v[0]}, 32'd0);
    chk("lat_data", {24'd0, dat_v[0]}, 32'hFD);
    @(negedge clk);
    chk("lat_wr_low2", {31'd0, wr_v[0]}, 32'd0);
    @(negedge clk);
    chk("lat_wr_rise", {31'd0, wr_v[0]}, 32'd1);
    wait_idle(200);
    chk("single_count", cap_q.size(), 32'd2);
    chk("single_hi", {23'd0, cap_q[0]}, 32'h1FD);
    chk("single_lo", {23'd0, cap_q[1]}, 32'h155);
    chk("single_lo_min", lo_min[0], 32'd2);
    chk("single_lo_max", lo_max[0], 32'd2);
    chk("single_hi_min", hi_min[0], 32'd2);
    chk("single_hi_max", hi_max[0], 32'd2);
    chk("single_cs_cnt", cs_lens.size(), 32'd1);
    chk("single_cs_len", cs_lens[0], 32'd8);

    // Start-of-frame pixel
    clear_stats();
    push(1'b1, 5'h00, 6'h3F, 5'h00, st);
    valid = 1'b0;
    wait_idle(200);
    chk("sof_cmd", {23'd0, cap_q[0]}, 32'h02C);
    chk("sof_hi", {23'd0, cap_q[1]}, 32'h107);
    chk("sof_lo", {23'd0, cap_q[2]}, 32'h1E0);
    chk("sof_rises", rise_cnt[0], 32'd3);
    chk("sof_cs_len", cs_lens[0], 32'd12);

    // Reset during the LO byte with a second pixel buffered
    clear_stats();
    push(1'b0, 5'h1F, 6'h2A, 5'h15, st);
    push(1'b0, 5'h00, 6'h00, 5'h01, st);
    valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_data", {24'd0, dat_v[0]}, 32'h00);
    chk("abort_dc", {31'd0, dc_v[0]}, 32'd1);
    chk("abort_wr_n", {31'd0, wr_v[0]}, 32'd1);
    chk("abort_cs_n", {31'd0, cs_v[0]}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_busy_after", {31'd0, busy}, 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_rises", rise_cnt[0], 32'd1);
    chk("abort_first_byte", {23'd0, cap_q[0]}, 32'h1FD);
    chk("abort_cs_stays", {31'd0, cs_v[0]}, 32'd1);

    // Burst of 10 pixels with valid held high
    clear_stats();
    stall_at = -1;
    for (int i = 0; i < 10; i++) begin
      push(1'b0, 5'(i * 3), 6'(i * 5 + 1), 5'(31 - i), st);
      if (st && stall_at < 0) stall_at = i;
    end
    valid = 1'b0;
    wait_idle(2000);
    chk("burst_stall_idx", stall_at, 32'd5);
    check_stream("burst");
    chk("burst_cs_cnt", cs_lens.size(), 32'd1);
    chk("burst_cs_len", cs_lens[0], 32'd80);

    // Push coinciding with a pop at FIFO depth-1
    clear_stats();
    for (int i = 0; i < 4; i++) push(1'b0, 5'(i + 1), 6'(i + 9), 5'(i + 20), st);
    valid = 1'b0;
    repeat (5) @(posedge clk);
    push(1'b0, 5'h0B, 6'h33, 5'h0E, st);
    valid = 1'b0;
    @(negedge clk);
    chk("simul_ready", {31'd0, ready}, 32'd1);
    wait_idle(500);
    check_stream("simul");

    // Randomised valid gaps over 1000 pixels, sof every 64
    clear_stats();
    for (int i = 0; i < 1000; i++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      push((i % 64) == 0, 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)),
           5'($urandom_range(0, 31)), st);
    end
    valid = 1'b0;
    wait_idle(20000);
    check_stream("rand");
    chk("rand_rises", rise_cnt[0], exp_q.size());
    chk("rand_lo_min", lo_min[0], 32'd2);
    chk("rand_lo_max", lo_max[0], 32'd2);
    chk("rand_hi_min", hi_min[0], 32'd2);
    chk("rand_hi_max", hi_max[0], 32'd2);

    // Strobe timing variants L=1/H=3 and L=3/H=1
    clear_stats();
    @(negedge clk);
    sof = 1'b1; red = 5'h10; green = 6'h01; blue = 5'h03; valid_bc = 1'b1;
    @(posedge clk);
    #1;
    sof = 1'b0; red = 5'h01; green = 6'h20; blue = 5'h1F;
    @(posedge clk);
    #1 valid_bc = 1'b0;
    w = 0;
    @(negedge clk);
    while ((busy_b || busy_c || !cs_v[1] || !cs_v[2]) && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("var_idle_b", {31'd0, busy_b}, 32'd0);
    chk("var_idle_c", {31'd0, busy_c}, 32'd0);
    @(negedge clk);
    #1;
    for (int k = 1; k < 3; k++) begin
      chk($sformatf("var%0d_rises", k), rise_cnt[k], 32'd5);
      for (int j = 0; j < 5; j++) begin
        chk($sformatf("var%0d_byte%0d", k, j), {23'd0, cap_bc[k-1][j]}, {23'd0, exp_bc[j]});
      end
      chk($sformatf("var%0d_lo_min", k), lo_min[k], (k == 1) ? 32'd1 : 32'd3);
      chk($sformatf("var%0d_lo_max", k), lo_max[k], (k == 1) ? 32'd1 : 32'd3);
      chk($sformatf("var%0d_hi_min", k), hi_min[k], (k == 1) ? 32'd3 : 32'd1);
      chk($sformatf("var%0d_hi_max", k), hi_max[k], (k == 1) ? 32'd3 : 32'd1);
      chk($sformatf("var%0d_cs_len", k), cs_last[k], 32'd20);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
